ofmap_spike_accumulator: RTL
============================

# ofmap_spike_accumulator

Downstream consumer of the psum adder stage. Takes the completed per-neuron partial sums in output-neuron order, integrates them into a bank of membrane potentials across timesteps, and emits one spike bit per neuron per timestep. It holds the entire output-feature-map state for one inference and flags completion after the last timestep.

## Interface
- DWIDTH, 8: width of incoming unsigned sum.
- MWIDTH, 16: membrane potential width, unsigned; MWIDTH >= DWIDTH.
- NUM_OUT, 25: output neurons per timestep.
- NUM_STEPS, 10: timesteps per inference.
- THRESHOLD, 64: firing threshold, 1 <= THRESHOLD <= 2^MWIDTH-1.
- IWIDTH, $clog2(NUM_OUT): neuron index width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_sum valid.
- in_ready  out  1  block accepts in_sum this cycle.
- in_sum  in  DWIDTH  partial sum for the current neuron.
- out_valid  out  1  spike result valid.
- out_ready  in  1  consumer accepts result.
- out_spike  out  1  1 = neuron fired.
- out_idx  out  IWIDTH  neuron index of the result.
- out_last  out  1  result is the final neuron of the final timestep.
- done  out  1  inference complete; level, held until clear.
- clear  in  1  synchronous one-cycle request to start a new inference.

## Operation
- States: CLEAR, RUN, DONE.
- CLEAR: sweeps mem[0..NUM_OUT-1] to 0, one entry per cycle; in_ready=0. Leaves for RUN after writing entry NUM_OUT-1. Resets idx and step to 0.
- RUN: in_ready = !clear && (!out_valid || out_ready). On accept: v = mem[idx] + in_sum, computed in MWIDTH+1 bits and clamped to 2^MWIDTH-1. If v >= THRESHOLD, spike=1 and mem[idx]=v-THRESHOLD; otherwise spike=0 and mem[idx]=v. The result is registered to out_* with out_idx=idx.
- Index increments per accept and wraps NUM_OUT-1 -> 0 with step++. The accept at idx=NUM_OUT-1, step=NUM_STEPS-1 sets out_last=1 on that result and moves to DONE.
- DONE: done=1, in_ready=0. A pending output still drains normally. Stays in DONE until clear.
- clear in RUN or DONE: next state is CLEAR, out_valid forced to 0 (a pending result is discarded), done is cleared. clear during CLEAR restarts the sweep at entry 0.
- clear and in_valid in the same cycle: clear wins. in_ready is 0, so no accept occurs.

## Timing
- Reset (async assert): state=CLEAR, idx=0, step=0, out_valid=0, out_spike=0, out_idx=0, out_last=0, done=0, in_ready=0. Memory contents are not reset by rst_n; the CLEAR sweep zeroes them.
- After rst_n deasserts, in_ready first rises on cycle NUM_OUT+1.
- Latency: the result appears on out_* the cycle after the accept.
- Throughput: 1 sum per cycle when out_ready=1.
- Backpressure: while out_valid && !out_ready, out_* stay stable and in_ready=0. Simultaneous out handshake and new accept are permitted (pipe-through).
- done rises the cycle after the final accept, together with out_valid/out_last.

## Structure
- Package ofmap_pkg holds the state enum typedef (CLEAR/RUN/DONE) and a saturating-add/threshold helper function.
- One sub-module: membrane_update. It is combinational: takes mem_in, sum and THRESHOLD and returns mem_out and spike, including the clamp.
- The top level holds the FSM, counters, memory array and output register.

## Test plan
- Reset release with NUM_OUT=4 -> in_ready low for exactly 4 cycles, then high. All outputs 0 throughout.
- NUM_OUT=1, THRESHOLD=64: sums 30 then 40 -> results spike=0, then spike=1; membrane afterwards is 6. Next sum 58 -> spike=1, membrane 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* unchanged for 3 cycles. After release, no result is lost or duplicated and indices run consecutively.
- MWIDTH=8, DWIDTH=8, THRESHOLD=250, membrane 200, sum 100 -> v clamps to 255, spike=1, membrane 5.
- NUM_OUT=4, NUM_STEPS=2, 8 consecutive accepts -> 8th result has out_idx=3 and out_last=1. done rises with it and in_ready stays 0 afterwards.
- In RUN, clear asserted with in_valid=1 and a stalled output -> no accept, out_valid drops, 4-cycle CLEAR. The first sum of 10 afterwards gives spike=0 (membrane restarted from 0).

Source files
------------

// File: rtl/ofmap_pkg.sv
// Shared types and the membrane integrate/fire helper for the ofmap spike accumulator.
package ofmap_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic        spike;
    logic [31:0] mem;
  } upd_t;

  // Saturating add of a sum into a membrane value, then threshold fire with subtractive reset.
  function automatic upd_t mem_update(input logic [31:0] mem_in,
                                      input logic [31:0] sum,
                                      input logic [31:0] thr,
                                      input logic [31:0] vmax);
    logic [32:0] v;
    upd_t        r;
    v = 33'(mem_in) + 33'(sum);
    if (v > 33'(vmax)) v = 33'(vmax);
    r.spike = (v >= 33'(thr));
    r.mem   = r.spike ? 32'(v - 33'(thr)) : 32'(v);
    return r;
  endfunction

endpackage

// File: rtl/ofmap_spike_accumulator_membrane_update.sv
// Combinational membrane update: clamp mem_in + sum to the membrane range, fire at THRESHOLD.
module membrane_update
  import ofmap_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MWIDTH    = 16,
  parameter int unsigned THRESHOLD = 64
) (
  input  logic [MWIDTH-1:0] mem_in,
  input  logic [DWIDTH-1:0] sum,
  output logic [MWIDTH-1:0] mem_out,
  output logic              spike
);

  localparam logic [31:0] VMAX = 32'((64'd1 << MWIDTH) - 64'd1);

  upd_t res;
  logic unused_mem;

  always_comb begin
    res = mem_update(32'(mem_in), 32'(sum), 32'(THRESHOLD), VMAX);
  end

  assign mem_out    = res.mem[MWIDTH-1:0];
  assign spike      = res.spike;
  // Result bits above MWIDTH are always zero after the clamp.
  assign unused_mem = ^res.mem;

endmodule

// File: rtl/ofmap_spike_accumulator.sv
// Integrates per-neuron partial sums into membrane potentials over timesteps and emits spikes.
module ofmap_spike_accumulator
  import ofmap_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MWIDTH    = 16,
  parameter int unsigned NUM_OUT   = 25,
  parameter int unsigned NUM_STEPS = 10,
  parameter int unsigned THRESHOLD = 64,
  parameter int unsigned IWIDTH    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_spike,
  output logic [IWIDTH-1:0] out_idx,
  output logic              out_last,
  output logic              done,
  input  logic              clear
);

  localparam int unsigned SWIDTH = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_t            state;
  logic [IWIDTH-1:0] idx;
  logic [SWIDTH-1:0] step;
  logic [MWIDTH-1:0] mem [NUM_OUT];
  logic [MWIDTH-1:0] mem_nxt;
  logic              spike_nxt;
  logic              accept;
  logic              last_idx;
  logic              last_step;

  assign in_ready  = (state == RUN) && !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_idx  = (idx == IWIDTH'(NUM_OUT - 1));
  assign last_step = (step == SWIDTH'(NUM_STEPS - 1));

  membrane_update #(
    .DWIDTH   (DWIDTH),
    .MWIDTH   (MWIDTH),
    .THRESHOLD(THRESHOLD)
  ) u_update (
    .mem_in (mem[idx]),
    .sum    (in_sum),
    .mem_out(mem_nxt),
    .spike  (spike_nxt)
  );

  // Membrane bank: not reset, zeroed by the CLEAR sweep using idx as the pointer.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (accept) begin
      mem[idx] <= mem_nxt;
    end
  end

  // Control FSM, counters and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      idx       <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      out_spike <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= CLEAR;
      idx       <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (last_idx) begin
            state <= RUN;
            idx   <= '0;
            step  <= '0;
          end else begin
            idx <= idx + IWIDTH'(1);
          end
        end
        RUN, DONE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (accept) begin
            out_valid <= 1'b1;
            out_spike <= spike_nxt;
            out_idx   <= idx;
            out_last  <= last_idx && last_step;
            if (last_idx) begin
              idx <= '0;
              if (last_step) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                step <= step + SWIDTH'(1);
              end
            end else begin
              idx <= idx + IWIDTH'(1);
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
